// File: rtl/alu_cpu_sequencer.sv
// alu_cpu_sequencer
//
// Control unit for the 8-bit ALU CPU datapath. Owns the program counter,
// instruction register, Z/C condition codes and a circular return stack.
// It steps every instruction through fetch -> decode -> execute -> (mem) ->
// (write_back) and parks in halt for wait/stby until woken.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   inst_stb_o/adr_o/dat_i/ack_i   instruction fetch handshake (address = PC)
//   data_stb_o/we_o/ack_i   data memory handshake for ldm/stm
//   port_stb_o/we_o/ack_i   I/O port handshake for inp/out
//   alu_z_i, alu_c_i        datapath ALU flags, sampled during execute
//   ir_o, state_o           instruction register and current sequencer state
//   gpr_we_o                register-file write enable (write_back only)
//   cc_z_o, cc_c_o          condition codes
//   wake_i, halted_o        halt exit request and halt indicator
module alu_cpu_sequencer #(
    parameter int IADDR_W     = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               inst_stb_o,
    output logic [IADDR_W-1:0] inst_adr_o,
    input  logic [17:0]        inst_dat_i,
    input  logic               inst_ack_i,
    output logic               data_stb_o,
    output logic               data_we_o,
    input  logic               data_ack_i,
    output logic               port_stb_o,
    output logic               port_we_o,
    input  logic               port_ack_i,
    input  logic               alu_z_i,
    input  logic               alu_c_i,
    output logic [17:0]        ir_o,
    output logic [2:0]         state_o,
    output logic               gpr_we_o,
    output logic               cc_z_o,
    output logic               cc_c_o,
    input  logic               wake_i,
    output logic               halted_o
);

    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEM        = 3'd3,
        S_WRITE_BACK = 3'd4,
        S_HALT       = 3'd5
    } state_t;

    state_t             state;
    logic [IADDR_W-1:0] pc;
    logic [17:0]        ir;
    logic               cc_z;
    logic               cc_c;
    logic [SP_W-1:0]    sp;
    logic [IADDR_W-1:0] stack [STACK_DEPTH];

    logic               is_alu;
    logic               is_mem;
    logic               is_jump;
    logic               is_branch;
    logic               is_misc;
    logic               branch_taken;
    logic               bus_ack;
    logic [SP_W-1:0]    sp_prev;
    logic [IADDR_W-1:0] jump_target;
    logic [IADDR_W-1:0] branch_target;

    // Instruction classes are a prefix code: each class adds one more
    // leading 1 before its terminating 0.
    assign is_alu    = (ir[17] == 1'b0) || (ir[17:15] == 3'b110) || (ir[17:14] == 4'b1110);
    assign is_mem    = (ir[17:16] == 2'b10);
    assign is_jump   = (ir[17:13] == 5'b11110);
    assign is_branch = (ir[17:12] == 6'b111110);
    assign is_misc   = (ir[17:11] == 7'b1111110);

    // PC has already been incremented past the branch when this is used,
    // so the displacement is relative to the following instruction.
    assign branch_target = pc + {{(IADDR_W-8){ir[7]}}, ir[7:0]};
    assign jump_target   = IADDR_W'(ir[11:0]);
    assign sp_prev       = sp - SP_W'(1);

    // mem_fn[1] selects the I/O port over data memory.
    assign bus_ack = ir[15] ? port_ack_i : data_ack_i;

    always_comb begin
        branch_taken = 1'b0;
        case (ir[11:10])
            2'b00:   branch_taken = cc_z;
            2'b01:   branch_taken = ~cc_z;
            2'b10:   branch_taken = cc_c;
            default: branch_taken = ~cc_c;
        endcase
    end

    // Strobes follow the state directly but are killed while reset is high,
    // so a pending bus request disappears in the same cycle reset arrives.
    assign inst_stb_o = ~rst_i && (state == S_FETCH);
    assign inst_adr_o = pc;
    assign data_stb_o = ~rst_i && (state == S_MEM) && ~ir[15];
    assign data_we_o  = data_stb_o && ir[14];
    assign port_stb_o = ~rst_i && (state == S_MEM) && ir[15];
    assign port_we_o  = port_stb_o && ir[14];
    assign gpr_we_o   = ~rst_i && (state == S_WRITE_BACK) && (ir[13:11] != 3'b000);
    assign halted_o   = (state == S_HALT);
    assign state_o    = state;
    assign ir_o       = ir;
    assign cc_z_o     = cc_z;
    assign cc_c_o     = cc_c;

    // Main sequencer. The return stack is circular: pushes past the depth
    // overwrite the oldest entry and pops on empty return whatever is stored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            cc_z  <= 1'b0;
            cc_c  <= 1'b0;
            sp    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (inst_ack_i) begin
                        ir    <= inst_dat_i;
                        pc    <= pc + IADDR_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    state <= S_FETCH;
                    if (is_alu) begin
                        cc_z  <= alu_z_i;
                        cc_c  <= alu_c_i;
                        state <= S_WRITE_BACK;
                    end else if (is_mem) begin
                        state <= S_MEM;
                    end else if (is_jump) begin
                        if (ir[12]) begin
                            stack[sp] <= pc;
                            sp        <= sp + SP_W'(1);
                        end
                        pc <= jump_target;
                    end else if (is_branch) begin
                        if (branch_taken) begin
                            pc <= branch_target;
                        end
                    end else if (is_misc) begin
                        case (ir[10:8])
                            3'b000: begin
                                sp <= sp_prev;
                                pc <= stack[sp_prev];
                            end
                            3'b100, 3'b101: state <= S_HALT;
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    // Loads and inputs need a register write; stores and outputs do not.
                    if (bus_ack) begin
                        state <= ir[14] ? S_FETCH : S_WRITE_BACK;
                    end
                end
                S_WRITE_BACK: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (wake_i) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cpu_sequencer.sv
// tb_alu_cpu_sequencer
//
// Drives alu_cpu_sequencer with directed and random instruction streams.
// An instruction-level model of the CPU predicts, for every instruction
// handed over on the fetch bus, the sequence of externally visible events
// (fetch address, decoded IR, bus access, write-back, halt entry). A monitor
// pops those predictions as the DUT produces the events.
module tb_alu_cpu_sequencer;

    localparam int IADDR_W     = 12;
    localparam int STACK_DEPTH = 8;

    logic               clk_i      = 1'b0;
    logic               rst_i      = 1'b1;
    logic               inst_stb_o;
    logic [IADDR_W-1:0] inst_adr_o;
    logic [17:0]        inst_dat_i = '0;
    logic               inst_ack_i = 1'b0;
    logic               data_stb_o;
    logic               data_we_o;
    logic               data_ack_i = 1'b0;
    logic               port_stb_o;
    logic               port_we_o;
    logic               port_ack_i = 1'b0;
    logic               alu_z_i    = 1'b0;
    logic               alu_c_i    = 1'b0;
    logic [17:0]        ir_o;
    logic [2:0]         state_o;
    logic               gpr_we_o;
    logic               cc_z_o;
    logic               cc_c_o;
    logic               wake_i     = 1'b0;
    logic               halted_o;

    alu_cpu_sequencer #(.IADDR_W(IADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_stb_o(inst_stb_o), .inst_adr_o(inst_adr_o),
        .inst_dat_i(inst_dat_i), .inst_ack_i(inst_ack_i),
        .data_stb_o(data_stb_o), .data_we_o(data_we_o), .data_ack_i(data_ack_i),
        .port_stb_o(port_stb_o), .port_we_o(port_we_o), .port_ack_i(port_ack_i),
        .alu_z_i(alu_z_i), .alu_c_i(alu_c_i),
        .ir_o(ir_o), .state_o(state_o), .gpr_we_o(gpr_we_o),
        .cc_z_o(cc_z_o), .cc_c_o(cc_c_o),
        .wake_i(wake_i), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {EV_FETCH, EV_DECODE, EV_DATA, EV_PORT, EV_WB, EV_HALT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
        int       aux;
    } ev_t;

    ev_t         exp_q[$];
    logic [17:0] prog_q[$];

    int errors = 0;
    int checks = 0;

    // Instruction-level CPU model
    int m_pc;
    bit m_z;
    bit m_c;
    int m_sp;
    int m_depth;
    int m_stack [STACK_DEPTH];

    // Stimulus controls
    bit          mon_en          = 1'b0;
    bit          random_mode     = 1'b0;
    bit          inst_always_ack = 1'b1;
    int          forced_delay    = -1;
    int          forced_halt_len = 0;
    int          cur_delay       = 0;
    int          bus_wait        = 0;
    int          halt_cnt        = 0;
    int          halt_len        = 1;
    int          issued          = 0;
    int          strobe_cnt      = 0;
    bit          prev_halted     = 1'b0;
    logic [17:0] drv_word;

    // The datapath's flags are modelled as fixed functions of the instruction word.
    function automatic bit flag_z(input logic [17:0] w);
        return w[0] ^ w[4];
    endfunction

    function automatic bit flag_c(input logic [17:0] w);
        return w[1] ^ w[6];
    endfunction

    function automatic void push_ev(input ev_kind_t k, input int v, input int a);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.aux  = a;
        exp_q.push_back(e);
    endfunction

    // Executes one instruction at ISA level and records the events it must produce.
    function automatic void model_issue(input logic [17:0] w, input int delay);
        int               next_pc;
        bit               taken;
        logic signed [7:0] disp;
        next_pc = (m_pc + 1) % 4096;
        push_ev(EV_DECODE, int'(w), 0);
        if (w[17] == 1'b0 || w[17:15] == 3'b110 || w[17:14] == 4'b1110) begin
            m_z = flag_z(w);
            m_c = flag_c(w);
            push_ev(EV_WB, int'(w[13:11] != 3'b000), int'({m_z, m_c}));
        end else if (w[17:16] == 2'b10) begin
            push_ev(w[15] ? EV_PORT : EV_DATA, int'(w[14]), delay + 1);
            if (!w[14]) push_ev(EV_WB, int'(w[13:11] != 3'b000), int'({m_z, m_c}));
        end else if (w[17:13] == 5'b11110) begin
            if (w[12]) begin
                m_stack[m_sp] = next_pc;
                m_sp = (m_sp + 1) % STACK_DEPTH;
                if (m_depth < STACK_DEPTH) m_depth++;
            end
            next_pc = int'(w[11:0]);
        end else if (w[17:12] == 6'b111110) begin
            case (w[11:10])
                2'd0:    taken = m_z;
                2'd1:    taken = !m_z;
                2'd2:    taken = m_c;
                default: taken = !m_c;
            endcase
            if (taken) begin
                disp    = w[7:0];
                next_pc = (next_pc + int'(disp)) & 4095;
            end
        end else if (w[17:11] == 7'b1111110) begin
            if (w[10:8] == 3'b000) begin
                m_sp    = (m_sp + STACK_DEPTH - 1) % STACK_DEPTH;
                next_pc = m_stack[m_sp];
                if (m_depth > 0) m_depth--;
            end else if (w[10:8] == 3'b100 || w[10:8] == 3'b101) begin
                push_ev(EV_HALT, 0, 0);
            end
        end
        m_pc = next_pc;
        push_ev(EV_FETCH, m_pc, 0);
    endfunction

    // Random instruction with a spread over all classes; ret only when something was pushed.
    function automatic logic [17:0] rand_word();
        logic [17:0] w;
        w = 18'($urandom);
        case ($urandom_range(0, 9))
            0, 1:    w[17] = 1'b0;
            2:       w[17:15] = 3'b110;
            3:       w[17:14] = 4'b1110;
            4, 5:    w[17:16] = 2'b10;
            6:       w[17:13] = 5'b11110;
            7:       w[17:12] = 6'b111110;
            8: begin
                w[17:11] = 7'b1111110;
                if (w[10:8] == 3'b000 && m_depth == 0) w[10:8] = 3'b001;
            end
            default: w[17:11] = 7'b1111111;
        endcase
        return w;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input string name, input int actual,
                             input int actual_aux, input bit use_aux);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: unexpected event with value 0x%0h, none predicted", name, actual);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            errors++;
            $display("[TB] FAIL %s: event kind %0d seen, required kind %0d (value 0x%0h)",
                     name, int'(k), int'(e.kind), e.val);
        end else if (actual != e.val || (use_aux && actual_aux != e.aux)) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h/0x%0h, required 0x%0h/0x%0h",
                     name, actual, actual_aux, e.val, e.aux);
        end
    endtask

    // Driver: responds to the DUT's requests just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        inst_ack_i = 1'b0;
        data_ack_i = 1'b0;
        port_ack_i = 1'b0;
        wake_i     = 1'b0;
        alu_z_i    = flag_z(ir_o);
        alu_c_i    = flag_c(ir_o);
        if (rst_i) begin
            bus_wait = 0;
            halt_cnt = 0;
        end else begin
            if (inst_stb_o && (prog_q.size() > 0 || random_mode) &&
                (inst_always_ack || $urandom_range(0, 2) != 0)) begin
                drv_word   = (prog_q.size() > 0) ? prog_q.pop_front() : rand_word();
                cur_delay  = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
                inst_dat_i = drv_word;
                inst_ack_i = 1'b1;
                model_issue(drv_word, cur_delay);
                issued++;
            end
            if (data_stb_o || port_stb_o) begin
                if (bus_wait >= cur_delay) begin
                    data_ack_i = data_stb_o;
                    port_ack_i = port_stb_o;
                    bus_wait   = 0;
                end else begin
                    bus_wait++;
                end
            end
            if (halted_o) begin
                if (halt_cnt == 0)
                    halt_len = (forced_halt_len > 0) ? forced_halt_len : int'($urandom_range(1, 4));
                halt_cnt++;
                if (halt_cnt >= halt_len) begin
                    wake_i   = 1'b1;
                    halt_cnt = 0;
                end
            end else begin
                halt_cnt = 0;
            end
        end
    end

    // Monitor: samples on the falling edge and matches observed events to predictions.
    always @(negedge clk_i) begin
        if (!mon_en || rst_i) begin
            strobe_cnt  = 0;
            prev_halted = 1'b0;
        end else begin
            if (inst_stb_o && inst_ack_i)
                expect_ev(EV_FETCH, "fetch address", int'(inst_adr_o), 0, 1'b0);
            if (state_o == 3'd1)
                expect_ev(EV_DECODE, "decoded ir", int'(ir_o), 0, 1'b0);
            if (data_stb_o || port_stb_o) begin
                strobe_cnt++;
                if (data_stb_o && data_ack_i) begin
                    expect_ev(EV_DATA, "data access we/strobe_cycles", int'(data_we_o), strobe_cnt, 1'b1);
                    strobe_cnt = 0;
                end else if (port_stb_o && port_ack_i) begin
                    expect_ev(EV_PORT, "port access we/strobe_cycles", int'(port_we_o), strobe_cnt, 1'b1);
                    strobe_cnt = 0;
                end
            end
            if (state_o == 3'd4)
                expect_ev(EV_WB, "write_back gpr_we/cc", int'(gpr_we_o), int'({cc_z_o, cc_c_o}), 1'b1);
            if (halted_o) begin
                if (!prev_halted) expect_ev(EV_HALT, "halt entry", 0, 0, 1'b0);
                check_output("strobes while halted", int'({inst_stb_o, data_stb_o, port_stb_o, gpr_we_o}), 0);
                check_output("state while halted", int'(state_o), 5);
            end
            prev_halted = halted_o;
        end
    end

    task automatic apply_stimulus(input logic [17:0] w);
        prog_q.push_back(w);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        prog_q.delete();
        @(posedge clk_i);
        #2;
        exp_q.delete();
        m_pc    = 0;
        m_z     = 1'b0;
        m_c     = 1'b0;
        m_sp    = 0;
        m_depth = 0;
        push_ev(EV_FETCH, 0, 0);
        @(negedge clk_i);
        check_output("reset state", int'(state_o), 0);
        check_output("reset pc", int'(inst_adr_o), 0);
        check_output("reset ir", int'(ir_o), 0);
        check_output("reset cc", int'({cc_z_o, cc_c_o}), 0);
        check_output("strobes in reset", int'({inst_stb_o, data_stb_o, port_stb_o, gpr_we_o, halted_o}), 0);
        @(posedge clk_i);
        #2;
        rst_i  = 1'b0;
        mon_en = 1'b1;
    endtask

    // Waits until the stream is consumed and the DUT sits in fetch waiting for more.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(prog_q.size() == 0 && !random_mode && state_o == 3'd0 &&
                 exp_q.size() == 1 && !inst_ack_i) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("[TB] FAIL %s: not idle after %0d cycles (state %0d, %0d events pending), required idle",
                     name, n, state_o, exp_q.size());
        end else if (exp_q[0].kind != EV_FETCH || int'(inst_adr_o) != exp_q[0].val) begin
            errors++;
            $display("[TB] FAIL %s: pending fetch address 0x%0h, required 0x%0h",
                     name, inst_adr_o, exp_q[0].val);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        do_reset();

        // First instruction: add rd=1 walks fetch, decode, execute, write_back.
        apply_stimulus(18'h00800);
        n = 0;
        while (state_o == 3'd0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_output("first instr decode state", int'(state_o), 1);
        @(negedge clk_i);
        check_output("first instr execute state", int'(state_o), 2);
        @(negedge clk_i);
        check_output("first instr write_back state", int'(state_o), 4);
        check_output("first instr gpr_we", int'(gpr_we_o), 1);
        @(negedge clk_i);
        check_output("first instr back to fetch", int'(state_o), 0);
        wait_idle("after first instr");
        check_output("pc after first instr", int'(inst_adr_o), 1);

        // Branches: Z set by the instruction at 4, bz at 5 goes back to 4, bnz falls through.
        apply_stimulus(18'h00002);
        apply_stimulus(18'h00810);
        apply_stimulus(18'h30800);
        apply_stimulus(18'h38801);
        apply_stimulus(18'h3E0FE);
        apply_stimulus(18'h00801);
        apply_stimulus(18'h3E4FE);
        wait_idle("branches");
        check_output("pc after bz/bnz", int'(inst_adr_o), 6);

        // ldm with a three-cycle late acknowledge, then zero-wait stm/inp/out.
        forced_delay = 3;
        apply_stimulus(18'h21000);
        wait_idle("delayed ldm");
        forced_delay = 0;
        apply_stimulus(18'h24000);
        apply_stimulus(18'h28800);
        apply_stimulus(18'h2C000);
        wait_idle("zero-wait bus");
        forced_delay = -1;
        check_output("pc after mem instrs", int'(inst_adr_o), 10);

        // jmp 0x010, jsb 0x100, ret.
        apply_stimulus(18'h3C010);
        apply_stimulus(18'h3D100);
        apply_stimulus(18'h3F000);
        wait_idle("jsb/ret");
        check_output("pc after jsb/ret", int'(inst_adr_o), 12'h011);

        // Nine nested calls on an eight-deep stack, then nine returns.
        for (int i = 0; i < 9; i++) apply_stimulus(18'h3D000 | 18'(12'h200 + 16 * i));
        for (int i = 0; i < 9; i++) apply_stimulus(18'h3F000);
        wait_idle("stack overflow");
        check_output("pc after 9th ret", int'(inst_adr_o), 12'h271);

        // wait with a long halt, stby with a short one, a misc no-op and an undefined opcode.
        forced_halt_len = 12;
        apply_stimulus(18'h3F400);
        wait_idle("wait halt");
        forced_halt_len = 0;
        check_output("pc after wait", int'(inst_adr_o), 12'h272);
        apply_stimulus(18'h3F500);
        apply_stimulus(18'h3F100);
        apply_stimulus(18'h3F800);
        wait_idle("stby/no-op");
        check_output("pc after stby/no-op", int'(inst_adr_o), 12'h275);

        // PC wraps from the top of instruction space.
        apply_stimulus(18'h3CFFF);
        apply_stimulus(18'h00800);
        wait_idle("pc wrap");
        check_output("pc after wrap", int'(inst_adr_o), 0);

        // Reset while a data request is outstanding.
        forced_delay = 50;
        apply_stimulus(18'h21000);
        n = 0;
        while (!data_stb_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_output("data strobe pending before reset", int'(data_stb_o), 1);
        @(negedge clk_i);
        #2;
        mon_en = 1'b0;
        rst_i  = 1'b1;
        #1;
        check_output("data strobe dropped with reset", int'(data_stb_o), 0);
        @(posedge clk_i);
        #1;
        check_output("state after mid-mem reset", int'(state_o), 0);
        check_output("pc after mid-mem reset", int'(inst_adr_o), 0);
        forced_delay = -1;
        do_reset();

        // Random instruction stream with random fetch stalls.
        inst_always_ack = 1'b0;
        issued          = 0;
        random_mode     = 1'b1;
        n = 0;
        while (issued < 400 && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        random_mode = 1'b0;
        check_output("random instructions issued", (issued >= 400) ? 1 : 0, 1);
        wait_idle("random stream");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
